tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the UART transmitter (2..8).
REQ-002 Parameter TIMEOUT, default 64: maximum clock cycles in START waiting for TxD_busy to rise.
REQ-003 clock  input  1  system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NREQ  per-requester send request; held with its data until the matching ack.
REQ-006 req_data  input  8*NREQ  byte of requester i on bits [8i+7:8i].
REQ-007 ack  output  NREQ  one-cycle pulse: byte of requester i accepted.
REQ-008 Tx_start  output  1  start strobe to the transmitter.
REQ-009 TxD_data  output  8  registered byte presented to the transmitter.
REQ-010 TxD_busy  input  1  transmitter busy flag.
REQ-011 grant_id  output  clog2(NREQ)  index of the requester currently owning the transmitter.
REQ-012 active  output  1  high whenever state is not IDLE.
REQ-013 frame_done  output  1  one-cycle pulse at end of each completed frame.
REQ-014 timeout_err  output  1  one-cycle pulse when TxD_busy fails to rise within TIMEOUT cycles.

Function
REQ-015 The FSM SHALL have states IDLE, START and WAIT_DONE.
REQ-016 IDLE: if any req bit is set and TxD_busy=0, the FSM SHALL select the winner, register its byte into TxD_data, set grant_id, pulse ack[winner] for that cycle, and enter START next cycle.
REQ-017 IDLE with TxD_busy=1: no grant, no ack; wait.
REQ-018 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NREQ; last_grant updates only on a grant.
REQ-019 START: Tx_start SHALL be 1 for every cycle in START and 0 in all other states.
REQ-020 START -> WAIT_DONE on the first cycle TxD_busy=1; the cycle counter clears on entry to START.
REQ-021 START -> IDLE with timeout_err pulse when the counter reaches TIMEOUT with TxD_busy still 0; no frame_done.
REQ-022 WAIT_DONE -> IDLE on the first cycle TxD_busy=0, pulsing frame_done that cycle.
REQ-023 TxD_data SHALL remain stable from grant until return to IDLE.
REQ-024 Exactly one ack per granted frame; at most one ack bit set in any cycle.
REQ-025 req changes after ack SHALL not affect the frame in progress; a requester still asserting req after ack is a new request.
REQ-026 Minimum grant-to-grant spacing: one IDLE cycle between frames (no back-to-back grant from WAIT_DONE).
REQ-027 Counter width SHALL hold TIMEOUT without wrap; counter saturates.

Reset
REQ-028 On reset_n=0 asynchronously: state IDLE, ack=0, Tx_start=0, TxD_data=0, grant_id=0, active=0, frame_done=0, timeout_err=0, counter=0, last_grant=NREQ-1 (requester 0 has first priority).
REQ-029 Reset mid-frame SHALL drop Tx_start immediately; no ack, frame_done or timeout_err is generated for the aborted frame.

Structure
REQ-030 Package tx_arb_pkg SHALL hold the state enumeration and the default NREQ/TIMEOUT constants.
REQ-031 Round-robin selection SHALL be a combinational sub-module tx_rr_picker (inputs req, last_grant; outputs valid, winner).

Verification
REQ-032 req=0001, data0=8'hA5, transmitter model raises busy 1 cycle after Tx_start, busy for 100 cycles -> ack=0001 once, TxD_data=A5, Tx_start 1 cycle, frame_done once, grant_id=0.
REQ-033 req=1111 held continuously after reset -> grant order 0,1,2,3,0; each ack once per frame.
REQ-034 Transmitter model never raises busy -> Tx_start high exactly 64 cycles, then timeout_err pulse, state IDLE, next req granted normally.
REQ-035 TxD_busy=1 externally in IDLE with req=0010 -> no ack until busy falls; ack 1 cycle later.
REQ-036 reset_n pulsed low during WAIT_DONE -> all outputs 0 asynchronously, no frame_done; after release req=0100 -> grant to requester 2.
REQ-037 req=0101, requester 0 withdraws req one cycle before grant -> requester 2 granted, ack=0100.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the FSM state encoding and default sizing constants.
package tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/tx_rr_picker.sv
// Combinational round-robin picker.
// Search begins one past the last grant and wraps modulo NREQ.
module tx_rr_picker #(
    parameter int NREQ = 4,
    parameter int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last_grant,
    output logic            valid,
    output logic [GW-1:0]   winner
);

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!valid && req[(int'(last_grant) + k) % NREQ]) begin
                valid  = 1'b1;
                winner = GW'((int'(last_grant) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Shares one UART transmitter among NREQ requesters (round-robin),
// drives the start strobe and watches for busy-rise timeout.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         ack,
    output logic                    Tx_start,
    output logic [7:0]              TxD_data,
    input  logic                    TxD_busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    active,
    output logic                    frame_done,
    output logic                    timeout_err
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    state_t            r_state;
    logic [GW-1:0]     r_last;
    logic [CW-1:0]     r_cnt;
    logic [NREQ-1:0]   r_ack;
    logic              r_txs;
    logic [7:0]        r_data;
    logic [GW-1:0]     r_gid;
    logic              r_fd;
    logic              r_to;

    logic              w_valid;
    logic [GW-1:0]     w_winner;
    logic [7:0]        w_data;

    tx_rr_picker #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .req        (req),
        .last_grant (r_last),
        .valid      (w_valid),
        .winner     (w_winner)
    );

    assign w_data = req_data[{w_winner, 3'b000} +: 8];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_last  <= GW'(NREQ - 1);
            r_cnt   <= '0;
            r_ack   <= '0;
            r_txs   <= 1'b0;
            r_data  <= '0;
            r_gid   <= '0;
            r_fd    <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_ack <= '0;
            r_fd  <= 1'b0;
            r_to  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_valid && !TxD_busy) begin
                        r_data  <= w_data;
                        r_gid   <= w_winner;
                        r_last  <= w_winner;
                        r_ack   <= ONE << w_winner;
                        r_cnt   <= '0;
                        r_txs   <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (TxD_busy) begin
                        r_txs   <= 1'b0;
                        r_state <= WAIT_DONE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        // This cycle would make TIMEOUT start-cycles in total.
                        r_txs   <= 1'b0;
                        r_to    <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_cnt != CW'(TIMEOUT)) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!TxD_busy) begin
                        r_fd    <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack         = r_ack;
    assign Tx_start    = r_txs;
    assign TxD_data    = r_data;
    assign grant_id    = r_gid;
    assign active      = (r_state != IDLE);
    assign frame_done  = r_fd;
    assign timeout_err = r_to;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with a simple transmitter model.
// Inputs change 1ns after the rising edge; the model acts on falling edges.
module tb_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              Tx_start;
    logic [7:0]        TxD_data;
    logic              TxD_busy;
    logic [1:0]        grant_id;
    logic              active;
    logic              frame_done;
    logic              timeout_err;

    tx_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .Tx_start    (Tx_start),
        .TxD_data    (TxD_data),
        .TxD_busy    (TxD_busy),
        .grant_id    (grant_id),
        .active      (active),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    int n_ack [NREQ];
    int n_txs, n_fd, n_to;
    int n_multi    = 0;
    int n_unstable = 0;
    int q_id[$];
    logic [7:0] q_dat[$];
    logic [7:0] hold;

    bit model_en  = 1'b0;
    int busy_left = 0;
    int busy_len  = 100;

    // Transmitter model: busy rises in the first Tx_start cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (model_en) begin
                if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) TxD_busy = 1'b0;
                end else if (Tx_start && !TxD_busy) begin
                    TxD_busy  = 1'b1;
                    busy_left = busy_len;
                end
            end
        end
    end

    task automatic clr();
        for (int i = 0; i < NREQ; i++) n_ack[i] = 0;
        n_txs = 0;
        n_fd  = 0;
        n_to  = 0;
        q_id.delete();
        q_dat.delete();
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (ack != '0) begin
            if ($countones(ack) != 1) n_multi++;
            hold = TxD_data;
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    n_ack[i]++;
                    q_id.push_back(i);
                    q_dat.push_back(TxD_data);
                end
            end
        end
        if (active && TxD_data !== hold) n_unstable++;
        if (Tx_start)    n_txs++;
        if (frame_done)  n_fd++;
        if (timeout_err) n_to++;
    endtask

    task automatic wait_ack(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (ack != '0) ok = 1'b1;
        end
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (frame_done || timeout_err) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        model_en  = 1'b0;
        busy_left = 0;
        TxD_busy  = 1'b0;
        req       = '0;
        reset_n   = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        req      = '0;
        TxD_busy = 1'b0;
        req_data = '0;
        #2;
        n_tests++;
        if ({ack, Tx_start, TxD_data, grant_id, active, frame_done,
             timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got ack=%b txs=%b data=%h gid=%0d act=%b fd=%b to=%b want all 0",
                     ack, Tx_start, TxD_data, grant_id, active, frame_done,
                     timeout_err);
        end
        step();
        reset_n = 1'b1;
        step();
        n_tests++;
        if (active !== 1'b0 || ack !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got act=%b ack=%b want 0/0", active, ack);
        end
    endtask

    task automatic test_single();
        bit ok;
        clr();
        model_en = 1'b1;
        busy_len = 100;
        req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
        req      = 4'b0001;
        wait_ack(20, ok);
        req = '0;
        n_tests++;
        if (!ok || ack !== 4'b0001 || TxD_data !== 8'hA5 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL single_grant: got ok=%b ack=%b data=%h gid=%0d want 1/0001/a5/0",
                     ok, ack, TxD_data, grant_id);
        end
        wait_end(300, ok);
        n_tests++;
        if (!ok || n_fd != 1 || n_to != 0) begin
            n_fail++;
            $display("FAIL single_done: got ok=%b fd=%0d to=%0d want 1/1/0", ok, n_fd, n_to);
        end
        n_tests++;
        if (n_txs != 1 || n_ack[0] != 1 || q_id.size() != 1) begin
            n_fail++;
            $display("FAIL single_counts: got txs=%0d ack0=%0d acks=%0d want 1/1/1",
                     n_txs, n_ack[0], q_id.size());
        end
        step();
        n_tests++;
        if (active !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got act=%b want 0", active);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_id [5];
        logic [7:0] exp_dat [5];
        int bad;
        exp_id  = '{0, 1, 2, 3, 0};
        exp_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        do_reset();
        clr();
        model_en = 1'b1;
        busy_len = 5;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req      = 4'b1111;
        for (int f = 0; f < 5; f++) wait_end(50, ok);
        req = '0;
        n_tests++;
        if (q_id.size() != 5 || n_fd != 5) begin
            n_fail++;
            $display("FAIL rr_count: got grants=%0d fd=%0d want 5/5", q_id.size(), n_fd);
        end
        bad = 0;
        for (int i = 0; i < 5 && i < q_id.size(); i++)
            if (q_id[i] != exp_id[i] || q_dat[i] !== exp_dat[i]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rr_order: got %0d wrong grants, want order 0,1,2,3,0", bad);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        clr();
        model_en = 1'b0;
        TxD_busy = 1'b0;
        req      = 4'b0010;
        wait_ack(20, ok);
        req = '0;
        n_tests++;
        if (!ok || grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL to_grant: got ok=%b gid=%0d want 1/1", ok, grant_id);
        end
        wait_end(200, ok);
        n_tests++;
        if (!ok || n_to != 1 || n_fd != 0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL to_pulse: got ok=%b to=%0d fd=%0d act=%b want 1/1/0/0",
                     ok, n_to, n_fd, active);
        end
        n_tests++;
        if (n_txs != TIMEOUT) begin
            n_fail++;
            $display("FAIL to_start_len: got %0d want %0d", n_txs, TIMEOUT);
        end
        clr();
        model_en = 1'b1;
        busy_len = 5;
        req      = 4'b0100;
        wait_ack(20, ok);
        req = '0;
        n_tests++;
        if (!ok || ack !== 4'b0100) begin
            n_fail++;
            $display("FAIL to_next_grant: got ok=%b ack=%b want 1/0100", ok, ack);
        end
        wait_end(50, ok);
        n_tests++;
        if (!ok || n_fd != 1 || n_to != 0) begin
            n_fail++;
            $display("FAIL to_next_done: got ok=%b fd=%0d to=%0d want 1/1/0", ok, n_fd, n_to);
        end
    endtask

    task automatic test_busy_idle();
        bit ok;
        clr();
        model_en = 1'b0;
        TxD_busy = 1'b1;
        req      = 4'b0010;
        repeat (8) step();
        n_tests++;
        if (q_id.size() != 0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_hold: got acks=%0d act=%b want 0/0", q_id.size(), active);
        end
        busy_left = 0;
        TxD_busy  = 1'b0;
        busy_len  = 5;
        model_en  = 1'b1;
        step();
        req = '0;
        n_tests++;
        if (ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL busy_release: got ack=%b want 0010", ack);
        end
        wait_end(50, ok);
        n_tests++;
        if (!ok || n_fd != 1) begin
            n_fail++;
            $display("FAIL busy_done: got ok=%b fd=%0d want 1/1", ok, n_fd);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clr();
        model_en = 1'b1;
        busy_len = 100;
        req      = 4'b0001;
        wait_ack(20, ok);
        req = '0;
        repeat (5) step();
        n_tests++;
        if (!ok || active !== 1'b1 || Tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait: got ok=%b act=%b txs=%b want 1/1/0", ok, active, Tx_start);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({ack, Tx_start, TxD_data, grant_id, active, frame_done,
             timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL mid_async: got ack=%b txs=%b data=%h gid=%0d act=%b want all 0",
                     ack, Tx_start, TxD_data, grant_id, active);
        end
        model_en  = 1'b0;
        busy_left = 0;
        TxD_busy  = 1'b0;
        clr();
        step();
        step();
        reset_n = 1'b1;
        repeat (3) step();
        n_tests++;
        if (n_fd != 0 || n_to != 0 || q_id.size() != 0) begin
            n_fail++;
            $display("FAIL mid_quiet: got fd=%0d to=%0d acks=%0d want 0/0/0",
                     n_fd, n_to, q_id.size());
        end
        model_en = 1'b1;
        busy_len = 5;
        req      = 4'b0100;
        wait_ack(20, ok);
        req = '0;
        n_tests++;
        if (!ok || ack !== 4'b0100 || grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL mid_regrant: got ok=%b ack=%b gid=%0d want 1/0100/2", ok, ack, grant_id);
        end
        wait_end(50, ok);
    endtask

    task automatic test_withdraw();
        bit ok;
        clr();
        model_en = 1'b0;
        TxD_busy = 1'b1;
        req      = 4'b0101;
        repeat (3) step();
        req = 4'b0100;
        step();
        busy_left = 0;
        TxD_busy  = 1'b0;
        busy_len  = 5;
        model_en  = 1'b1;
        step();
        req = '0;
        n_tests++;
        if (ack !== 4'b0100 || n_ack[0] != 0) begin
            n_fail++;
            $display("FAIL withdraw: got ack=%b ack0=%0d want 0100/0", ack, n_ack[0]);
        end
        wait_end(50, ok);
        n_tests++;
        if (!ok || n_fd != 1) begin
            n_fail++;
            $display("FAIL withdraw_done: got ok=%b fd=%0d want 1/1", ok, n_fd);
        end
        n_tests++;
        if (n_multi != 0 || n_unstable != 0) begin
            n_fail++;
            $display("FAIL ack_data_integrity: got multi=%0d unstable=%0d want 0/0",
                     n_multi, n_unstable);
        end
    endtask

    initial begin
        hold = '0;
        clr();
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_busy_idle();
        test_reset_mid();
        test_withdraw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
